// File: rtl/calc_operand_sequencer.sv
// -----------------------------------------------------------------------------
// calc_operand_sequencer
//   Front-end control stage for the three-number calculator. Synchronises and
//   edge-detects the raw "enter" button, captures operands A, B, C and operator
//   codes op1, op2 from the switches, then evaluates (A op1 B) op2 C over two
//   cycles and holds the result with an overflow flag.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enter_raw    asynchronous push-button, active-high
//   clear        synchronous soft clear, active-high (wins over enter)
//   operand_in   WIDTH-1 bit two's-complement operand switches
//   op_in        operator: 00 add, 01 sub, 10 AND, 11 OR
//   result       WIDTH bit two's-complement final value
//   ovf          final value outside the (WIDTH-1)-bit signed range
//   result_valid high in DONE
//   busy         high in CALC1/CALC2
//   stage        current state code for LEDs
// -----------------------------------------------------------------------------
module calc_operand_sequencer #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter_raw,
  input  logic             clear,
  input  logic [WIDTH-2:0] operand_in,
  input  logic [1:0]       op_in,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             result_valid,
  output logic             busy,
  output logic [2:0]       stage
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_B = 3'd1,
    GET_C = 3'd2,
    CALC1 = 3'd3,
    CALC2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // Bounds of the operand-width signed range, expressed in the widened f width.
  localparam logic signed [WIDTH:0] F_MAX = (WIDTH+1)'(2**(WIDTH-2) - 1);
  localparam logic signed [WIDTH:0] F_MIN = ~F_MAX;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic                   enter_pulse;

  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, r1_q, r1_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic [1:0]              op1_q, op1_d, op2_q, op2_d;
  logic                    ovf_q, ovf_d;

  logic signed [WIDTH-1:0] operand_sext;
  logic signed [WIDTH-1:0] r1_calc;
  logic signed [WIDTH:0]   r1_x, c_x, f;

  assign enter_pulse  = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
  assign operand_sext = {operand_in[WIDTH-2], operand_in};

  // First step fits in WIDTH bits exactly; second step widens by one bit so
  // the range test sees the true value before truncation.
  always_comb begin
    r1_calc = '0;
    case (op1_q)
      OP_ADD:  r1_calc = a_q + b_q;
      OP_SUB:  r1_calc = a_q - b_q;
      OP_AND:  r1_calc = a_q & b_q;
      default: r1_calc = a_q | b_q;
    endcase
  end

  always_comb begin
    r1_x = {r1_q[WIDTH-1], r1_q};
    c_x  = {c_q[WIDTH-1], c_q};
    f    = '0;
    case (op2_q)
      OP_ADD:  f = r1_x + c_x;
      OP_SUB:  f = r1_x - c_x;
      OP_AND:  f = r1_x & c_x;
      default: f = r1_x | c_x;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], enter_raw};
    sync_dly_d = sync_q[SYNC_STAGES-1];
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    r1_d       = r1_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    result_d   = result_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: if (enter_pulse) begin
        a_d     = operand_sext;
        op1_d   = op_in;
        state_d = GET_B;
      end
      GET_B: if (enter_pulse) begin
        b_d     = operand_sext;
        op2_d   = op_in;
        state_d = GET_C;
      end
      GET_C: if (enter_pulse) begin
        c_d     = operand_sext;
        state_d = CALC1;
      end
      CALC1: begin
        r1_d    = r1_calc;
        state_d = CALC2;
      end
      CALC2: begin
        result_d = f[WIDTH-1:0];
        ovf_d    = (f > F_MAX) || (f < F_MIN);
        state_d  = DONE;
      end
      DONE: if (enter_pulse) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Overrides whatever the state machine chose, including a coincident pulse.
    if (clear) begin
      state_d  = IDLE;
      a_d      = '0;
      b_d      = '0;
      c_d      = '0;
      r1_d     = '0;
      op1_d    = '0;
      op2_d    = '0;
      result_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      r1_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      r1_q       <= r1_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end

  assign result       = result_q;
  assign ovf          = ovf_q;
  assign stage        = state_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q == CALC1) || (state_q == CALC2);

endmodule

// File: tb/tb_calc_operand_sequencer.sv
module tb_calc_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enter_raw;
  logic        clear;
  logic [9:0]  operand_in;
  logic [1:0]  op_in;
  logic [10:0] result;
  logic        ovf;
  logic        result_valid;
  logic        busy;
  logic [2:0]  stage;

  int checks   = 0;
  int failures = 0;
  int exp_res  = 0;
  int exp_ovf  = 0;
  bit started  = 1'b0;

  calc_operand_sequencer #(.WIDTH(11), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enter_raw(enter_raw), .clear(clear),
    .operand_in(operand_in), .op_in(op_in), .result(result), .ovf(ovf),
    .result_valid(result_valid), .busy(busy), .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int apply(input int x, input int op, input int y);
    case (op)
      0:       return x + y;
      1:       return x - y;
      2:       return x & y;
      default: return x | y;
    endcase
  endfunction

  // Calculator semantics: (a op1 b) op2 c on signed integers, result is the
  // 11-bit truncation, overflow means outside [-512, 511].
  task automatic model(input int a, input int o1, input int b, input int o2,
                       input int c, output int res, output int ov);
    int f;
    f   = apply(apply(a, o1, b), o2, c);
    res = f & 'h7FF;
    ov  = ((f < -512) || (f > 511)) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean press: raw high long enough for the capture edge, then release
  // and scramble the switches to show they are only sampled at capture.
  task automatic press(input int v, input int op);
    operand_in = 10'(v);
    op_in      = 2'(op);
    enter_raw  = 1'b1;
    repeat (4) tick();
    enter_raw  = 1'b0;
    operand_in = ~operand_in;
    op_in      = ~op_in;
    repeat (3) tick();
  endtask

  // Enter C and step through the timing edge by edge.
  task automatic run_c(input int v, input string nm);
    operand_in = 10'(v);
    enter_raw  = 1'b1;
    tick(); chk({nm, " pre1 stage"}, int'(stage), 2);
    tick(); chk({nm, " pre2 stage"}, int'(stage), 2);
    tick(); chk({nm, " calc1 stage"}, int'(stage), 3);
    chk({nm, " calc1 busy"}, int'(busy), 1);
    chk({nm, " calc1 valid"}, int'(result_valid), 0);
    tick(); chk({nm, " calc2 stage"}, int'(stage), 4);
    chk({nm, " calc2 busy"}, int'(busy), 1);
    tick(); chk({nm, " done stage"}, int'(stage), 5);
    chk({nm, " done valid"}, int'(result_valid), 1);
    chk({nm, " done busy"}, int'(busy), 0);
    chk({nm, " result"}, int'(result), exp_res);
    chk({nm, " ovf"}, int'(ovf), exp_ovf);
    enter_raw  = 1'b0;
    operand_in = ~operand_in;
    repeat (3) tick();
    chk({nm, " held result"}, int'(result), exp_res);
    chk({nm, " held stage"}, int'(stage), 5);
  endtask

  task automatic seq(input int a, input int o1, input int b, input int o2,
                     input int c, input string nm);
    model(a, o1, b, o2, c, exp_res, exp_ovf);
    press(a, o1);
    chk({nm, " stage B"}, int'(stage), 1);
    press(b, o2);
    chk({nm, " stage C"}, int'(stage), 2);
    run_c(c, nm);
  endtask

  // Continuous consistency check against the model whenever outputs matter.
  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("busy vs stage", int'(busy), (stage == 3'd3 || stage == 3'd4) ? 1 : 0);
      chk("valid vs stage", int'(result_valid), (stage == 3'd5) ? 1 : 0);
      if (result_valid) begin
        chk("cmp result", int'(result), exp_res);
        chk("cmp ovf", int'(ovf), exp_ovf);
      end
    end
  end

  initial begin
    int r, o;
    rst_n = 1'b0; enter_raw = 1'b0; clear = 1'b0; operand_in = '0; op_in = '0;

    // Pin the model with hand-computed values.
    model(100, 0, 200, 0, 300, r, o);    chk("model1 res", r, 600); chk("model1 ovf", o, 1);
    model(-5, 1, 3, 0, 10, r, o);        chk("model2 res", r, 2);   chk("model2 ovf", o, 0);
    model(-512, 1, 511, 1, 511, r, o);   chk("model3 res", r, 'h202); chk("model3 ovf", o, 1);
    model(-16, 2, 15, 2, 123, r, o);     chk("model4 res", r, 0);   chk("model4 ovf", o, 0);

    repeat (3) tick();
    chk("reset stage", int'(stage), 0);
    chk("reset result", int'(result), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset valid", int'(result_valid), 0);
    chk("reset busy", int'(busy), 0);
    #2 rst_n = 1'b1;
    started = 1'b1;
    repeat (2) tick();

    seq(100, 0, 200, 0, 300, "s1");
    press(0, 0);
    chk("s1 done->idle", int'(stage), 0);

    seq(-5, 1, 3, 0, 10, "s2");
    press(0, 0);
    chk("s2 done->idle stage", int'(stage), 0);
    chk("s2 done->idle valid", int'(result_valid), 0);
    chk("s2 done->idle result", int'(result), 2);

    seq(-512, 1, 511, 1, 511, "s3");
    press(0, 0);

    // Clear coincident with the C pulse.
    press(1, 0);
    press(2, 0);
    operand_in = 10'd5;
    enter_raw  = 1'b1;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear stage", int'(stage), 0);
    chk("clear result", int'(result), 0);
    chk("clear ovf", int'(ovf), 0);
    chk("clear valid", int'(result_valid), 0);
    enter_raw = 1'b0;
    repeat (3) tick();
    chk("clear stays idle", int'(stage), 0);

    seq('h3F0, 2, 'h00F, 2, 'h155, "s4 and");
    press(0, 0);

    // Long hold: one advance only; then a sub-cycle glitch between edges.
    operand_in = 10'd7; op_in = 2'd0; enter_raw = 1'b1;
    repeat (50) tick();
    chk("hold stage", int'(stage), 1);
    enter_raw = 1'b0;
    repeat (3) tick();
    chk("hold release stage", int'(stage), 1);
    #2 enter_raw = 1'b1;
    #3 enter_raw = 1'b0;
    repeat (4) tick();
    chk("glitch stage", int'(stage), 1);
    press(8, 0);
    chk("s5 stage C", int'(stage), 2);

    // Second pulse lands while in CALC2 and must be ignored, not queued.
    model(7, 0, 8, 0, 9, exp_res, exp_ovf);
    operand_in = 10'd9; enter_raw = 1'b1;
    tick(); enter_raw = 1'b0;
    tick(); enter_raw = 1'b1;
    tick(); chk("s5 calc1", int'(stage), 3);
    tick(); chk("s5 calc2", int'(stage), 4);
    tick(); chk("s5 ignore", int'(stage), 5);
    tick(); chk("s5 not queued", int'(stage), 5);
    chk("s5 result", int'(result), 24);
    enter_raw = 1'b0;
    repeat (3) tick();
    press(0, 0);

    // Asynchronous reset between edges during CALC1.
    press(1, 0);
    press(2, 1);
    operand_in = 10'd3; enter_raw = 1'b1;
    repeat (3) tick();
    chk("pre-reset stage", int'(stage), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("areset stage", int'(stage), 0);
    chk("areset busy", int'(busy), 0);
    chk("areset result", int'(result), 0);
    chk("areset ovf", int'(ovf), 0);
    chk("areset valid", int'(result_valid), 0);
    enter_raw = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    repeat (2) tick();
    chk("restart stage", int'(stage), 0);
    seq(10, 1, 20, 3, 3, "s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
